// File: rtl/spi_flash_responder_pkg.sv
// Shared definitions for the SPI flash responder: command codes, FSM states,
// synchroniser event bundle and the JEDEC ID byte selector.
package spi_flash_responder_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned BIT_CNT_W  = 3;
    localparam int unsigned BYTE_CNT_W = 2;
    localparam int unsigned SPI_ADDR_W = 24;

    localparam logic [BYTE_W-1:0] CMD_READ = 8'h03;
    localparam logic [BYTE_W-1:0] CMD_RDID = 8'h9F;
    localparam logic [BYTE_W-1:0] CMD_RDSR = 8'h05;

    // FETCH/LOAD cover the two-clock memory read between the address phase and DATA
    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_CMD    = 4'd1,
        ST_ADDR   = 4'd2,
        ST_FETCH  = 4'd3,
        ST_LOAD   = 4'd4,
        ST_DATA   = 4'd5,
        ST_ID     = 4'd6,
        ST_STAT   = 4'd7,
        ST_IGNORE = 4'd8
    } state_e;

    typedef struct packed {
        logic sclk_rise;
        logic sclk_fall;
        logic cs_fall;
        logic cs_high;
        logic mosi;
    } sync_evt_t;

    // RDID byte sequence: ID bytes MSB first, then zeros forever
    function automatic logic [BYTE_W-1:0] id_byte(input logic [SPI_ADDR_W-1:0] id,
                                                  input logic [BYTE_CNT_W-1:0] idx);
        case (idx)
            2'd0:    return id[23:16];
            2'd1:    return id[15:8];
            2'd2:    return id[7:0];
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/spi_flash_responder_if.sv
// Flash bus plus backing-memory port of the SPI flash responder.
interface spi_flash_responder_if #(
    parameter int unsigned MEM_ADDR_BITS = 16
) ();
    logic                     spiSclk;
    logic                     spiCs;
    logic                     spiMosi;
    logic                     spiMiso;
    logic [MEM_ADDR_BITS-1:0] memAddr;
    logic                     memRd;
    logic [7:0]               memData;
    logic                     busy;
    logic                     cmdValid;
    logic [7:0]               cmdByte;

    modport slave (
        input  spiSclk, spiCs, spiMosi, memData,
        output spiMiso, memAddr, memRd, busy, cmdValid, cmdByte
    );

    modport master (
        output spiSclk, spiCs, spiMosi, memData,
        input  spiMiso, memAddr, memRd, busy, cmdValid, cmdByte
    );
endinterface

// File: rtl/spi_flash_responder_input_sync.sv
// Synchronises SCLK/CS/MOSI into clk and emits registered edge/level events.
module spi_flash_responder_input_sync
    import spi_flash_responder_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      sclk_i,
    input  logic      cs_i,
    input  logic      mosi_i,
    output sync_evt_t evt_o
);

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    sync_evt_t              evt_q;

    // Top chain stage doubles as the "previous" value for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            evt_q       <= '{sclk_rise: 1'b0, sclk_fall: 1'b0, cs_fall: 1'b0,
                             cs_high: 1'b1, mosi: 1'b0};
        end else begin
            sclk_sync_q     <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
            cs_sync_q       <= {cs_sync_q[SYNC_STAGES-2:0], cs_i};
            mosi_sync_q     <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
            evt_q.sclk_rise <= sclk_sync_q[SYNC_STAGES-2] & ~sclk_sync_q[SYNC_STAGES-1];
            evt_q.sclk_fall <= ~sclk_sync_q[SYNC_STAGES-2] & sclk_sync_q[SYNC_STAGES-1];
            evt_q.cs_fall   <= ~cs_sync_q[SYNC_STAGES-2] & cs_sync_q[SYNC_STAGES-1];
            evt_q.cs_high   <= cs_sync_q[SYNC_STAGES-2];
            evt_q.mosi      <= mosi_sync_q[SYNC_STAGES-1];
        end
    end

    assign evt_o = evt_q;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 target emulating a read-only NOR flash (READ/RDID/RDSR)
// on top of an on-chip byte memory with a one-cycle read latency.
module spi_flash_responder
    import spi_flash_responder_pkg::*;
#(
    parameter int unsigned           MEM_ADDR_BITS = 16,
    parameter logic [SPI_ADDR_W-1:0] JEDEC_ID      = 24'hEF4017,
    parameter int unsigned           SYNC_STAGES   = 2
) (
    input logic                  clk,
    input logic                  rst,
    spi_flash_responder_if.slave bus
);

    localparam int unsigned ADDR_SH_W = MEM_ADDR_BITS - 1;

    sync_evt_t evt;

    spi_flash_responder_input_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_input_sync (
        .clk    (clk),
        .rst    (rst),
        .sclk_i (bus.spiSclk),
        .cs_i   (bus.spiCs),
        .mosi_i (bus.spiMosi),
        .evt_o  (evt)
    );

    state_e                   state_q,    state_d;
    logic [BIT_CNT_W-1:0]     bit_cnt_q,  bit_cnt_d;
    logic [BYTE_CNT_W-1:0]    byte_cnt_q, byte_cnt_d;
    logic [BYTE_W-2:0]        rx_q,       rx_d;
    logic [ADDR_SH_W-1:0]     addr_q,     addr_d;
    logic [BYTE_W-1:0]        tx_q,       tx_d;
    logic [BYTE_W-1:0]        next_q,     next_d;
    logic                     pend_q,     pend_d;
    logic                     miso_q,     miso_d;
    logic [MEM_ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
    logic                     mem_rd_q,   mem_rd_d;
    logic                     busy_q,     busy_d;
    logic                     cmd_valid_q, cmd_valid_d;
    logic [BYTE_W-1:0]        cmd_byte_q, cmd_byte_d;

    logic [BYTE_W-1:0]        cmd_word;
    logic [BYTE_W-1:0]        load_byte;
    logic [BYTE_W-1:0]        out_byte;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            rx_q        <= '0;
            addr_q      <= '0;
            tx_q        <= '0;
            next_q      <= '0;
            pend_q      <= 1'b0;
            miso_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_rd_q    <= 1'b0;
            busy_q      <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_byte_q  <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            rx_q        <= rx_d;
            addr_q      <= addr_d;
            tx_q        <= tx_d;
            next_q      <= next_d;
            pend_q      <= pend_d;
            miso_q      <= miso_d;
            mem_addr_q  <= mem_addr_d;
            mem_rd_q    <= mem_rd_d;
            busy_q      <= busy_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_byte_q  <= cmd_byte_d;
        end
    end

    // Byte that starts shifting out at the first fall of each response byte
    always_comb begin
        cmd_word = {rx_q, evt.mosi};
        case (state_q)
            ST_DATA: load_byte = next_q;
            ST_ID:   load_byte = id_byte(JEDEC_ID, byte_cnt_q);
            default: load_byte = '0;
        endcase
        out_byte = (bit_cnt_q == '0) ? load_byte : tx_q;
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        rx_d        = rx_q;
        addr_d      = addr_q;
        tx_d        = tx_q;
        next_d      = pend_q ? bus.memData : next_q;
        pend_d      = mem_rd_q;
        miso_d      = miso_q;
        mem_addr_d  = mem_addr_q;
        mem_rd_d    = 1'b0;
        busy_d      = busy_q;
        cmd_valid_d = 1'b0;
        cmd_byte_d  = cmd_byte_q;

        // CS high overrides any coincident SCLK edge
        if (evt.cs_high) begin
            state_d    = ST_IDLE;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
            miso_d     = 1'b0;
            busy_d     = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (evt.cs_fall) begin
                        state_d    = ST_CMD;
                        busy_d     = 1'b1;
                        bit_cnt_d  = '0;
                        byte_cnt_d = '0;
                    end
                end
                ST_CMD: begin
                    if (evt.sclk_rise) begin
                        rx_d      = {rx_q[BYTE_W-3:0], evt.mosi};
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                        if (bit_cnt_q == BIT_CNT_W'(7)) begin
                            cmd_valid_d = 1'b1;
                            cmd_byte_d  = cmd_word;
                            byte_cnt_d  = '0;
                            case (cmd_word)
                                CMD_READ: state_d = ST_ADDR;
                                CMD_RDID: state_d = ST_ID;
                                CMD_RDSR: state_d = ST_STAT;
                                default:  state_d = ST_IGNORE;
                            endcase
                        end
                    end
                end
                ST_ADDR: begin
                    if (evt.sclk_rise) begin
                        addr_d    = {addr_q[ADDR_SH_W-2:0], evt.mosi};
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                        if (bit_cnt_q == BIT_CNT_W'(7)) begin
                            byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
                            if (byte_cnt_q == BYTE_CNT_W'(2)) begin
                                mem_addr_d = {addr_q, evt.mosi};
                                state_d    = ST_FETCH;
                            end
                        end
                    end
                end
                ST_FETCH: begin
                    mem_rd_d = 1'b1;
                    state_d  = ST_LOAD;
                end
                ST_LOAD: begin
                    if (pend_q) begin
                        state_d = ST_DATA;
                    end
                end
                ST_DATA, ST_ID, ST_STAT: begin
                    if (evt.sclk_fall) begin
                        miso_d    = out_byte[BYTE_W-1];
                        tx_d      = {out_byte[BYTE_W-2:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                        if (bit_cnt_q == BIT_CNT_W'(7)) begin
                            if (byte_cnt_q != BYTE_CNT_W'(3)) begin
                                byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
                            end
                            // Prefetch the next byte while bit0 is on the wire
                            if (state_q == ST_DATA) begin
                                mem_addr_d = mem_addr_q + MEM_ADDR_BITS'(1);
                                mem_rd_d   = 1'b1;
                            end
                        end
                    end
                end
                ST_IGNORE: begin
                    miso_d = 1'b0;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign bus.spiMiso  = miso_q;
    assign bus.memAddr  = mem_addr_q;
    assign bus.memRd    = mem_rd_q;
    assign bus.busy     = busy_q;
    assign bus.cmdValid = cmd_valid_q;
    assign bus.cmdByte  = cmd_byte_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: READ, RDID, RDSR, address wrap,
// CS abort, unknown command and asynchronous reset mid-byte.
module tb_spi_flash_responder;
    import spi_flash_responder_pkg::*;

    localparam int unsigned HALF = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_flash_responder_if #(.MEM_ADDR_BITS(16)) bus ();

    spi_flash_responder #(
        .MEM_ADDR_BITS (16),
        .JEDEC_ID      (24'hEF4017),
        .SYNC_STAGES   (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Backing memory: mem[i] = i ^ 0xA5, data valid the cycle after memRd
    always @(posedge clk or posedge rst) begin
        if (rst)            bus.memData <= 8'h00;
        else if (bus.memRd) bus.memData <= bus.memAddr[7:0] ^ 8'hA5;
    end

    int          rd_cnt = 0;
    int          cv_cnt = 0;
    int          viol   = 0;
    logic        rd_prev = 1'b0;
    logic        cv_prev = 1'b0;
    logic [15:0] rd_log[$];

    always @(posedge clk) begin
        if (!rst) begin
            if (bus.memRd) begin
                rd_cnt++;
                rd_log.push_back(bus.memAddr);
            end
            if (bus.cmdValid) cv_cnt++;
            if ((bus.memRd && rd_prev) || (bus.cmdValid && cv_prev)) viol++;
            rd_prev <= bus.memRd;
            cv_prev <= bus.cmdValid;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Mode 0: MOSI set while SCLK low, MISO sampled just before the rise
    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            bus.spiMosi = tx[i];
            tick(HALF);
            rx[i] = bus.spiMiso;
            bus.spiSclk = 1'b1;
            tick(HALF);
            bus.spiSclk = 1'b0;
        end
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        spi_bits(tx, 8, rx);
    endtask

    task automatic cs_start();
        bus.spiCs = 1'b0;
        tick(HALF);
    endtask

    task automatic cs_end();
        tick(HALF);
        bus.spiCs = 1'b1;
        tick(2 * HALF);
    endtask

    initial begin
        logic [7:0] rx;
        int         rd_base;
        int         cv_base;
        logic [7:0] exp_read[4] = '{8'hB5, 8'hB4, 8'hB7, 8'hB6};
        logic [7:0] exp_id[5]   = '{8'hEF, 8'h40, 8'h17, 8'h00, 8'h00};

        bus.spiSclk = 1'b0;
        bus.spiCs   = 1'b1;
        bus.spiMosi = 1'b0;
        tick(3);
        check("rst_miso",     bus.spiMiso,  0);
        check("rst_memaddr",  bus.memAddr,  0);
        check("rst_memrd",    bus.memRd,    0);
        check("rst_busy",     bus.busy,     0);
        check("rst_cmdvalid", bus.cmdValid, 0);
        check("rst_cmdbyte",  bus.cmdByte,  0);
        rst = 1'b0;
        tick(4);

        // READ 0x000010, four data bytes
        rd_base = rd_cnt;
        cv_base = cv_cnt;
        cs_start();
        spi_byte(CMD_READ, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h10, rx);
        for (int i = 0; i < 4; i++) begin
            spi_byte(8'h00, rx);
            check($sformatf("read_b%0d", i), rx, exp_read[i]);
        end
        check("read_busy_open", bus.busy, 1);
        cs_end();
        check("read_busy_closed", bus.busy, 0);
        // initial fetch plus one prefetch as bit0 of each of the 4 bytes is driven
        check("read_memrd_cnt",  rd_cnt - rd_base, 5);
        check("read_addr_first", rd_log[rd_base], 16'h0010);
        check("read_addr_last",  rd_log[rd_base + 4], 16'h0014);
        check("read_cmdvalid",   cv_cnt - cv_base, 1);
        check("read_cmdbyte",    bus.cmdByte, 8'h03);

        // RDID, five bytes
        cs_start();
        spi_byte(CMD_RDID, rx);
        for (int i = 0; i < 5; i++) begin
            spi_byte(8'h00, rx);
            check($sformatf("rdid_b%0d", i), rx, exp_id[i]);
        end
        cs_end();

        // RDSR, two bytes
        cs_start();
        spi_byte(CMD_RDSR, rx);
        for (int i = 0; i < 2; i++) begin
            spi_byte(8'hFF, rx);
            check($sformatf("rdsr_b%0d", i), rx, 8'h00);
        end
        check("rdsr_cmdbyte", bus.cmdByte, 8'h05);
        cs_end();

        // Address wrap at 0xFFFF
        rd_base = rd_cnt;
        cs_start();
        spi_byte(CMD_READ, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'hFF, rx);
        spi_byte(8'hFF, rx);
        spi_byte(8'h00, rx);
        check("wrap_b0", rx, 8'h5A);
        spi_byte(8'h00, rx);
        check("wrap_b1", rx, 8'hA5);
        cs_end();
        check("wrap_addr0", rd_log[rd_base], 16'hFFFF);
        check("wrap_addr1", rd_log[rd_base + 1], 16'h0000);

        // Abort a READ after 13 bits, CS rises with the last SCLK fall
        rd_base = rd_cnt;
        cs_start();
        spi_byte(CMD_READ, rx);
        spi_bits(8'h00, 5, rx);
        bus.spiCs = 1'b1;
        tick(3);
        check("abort_busy", bus.busy, 0);
        check("abort_no_memrd", rd_cnt - rd_base, 0);
        tick(2 * HALF);
        cs_start();
        spi_byte(CMD_RDID, rx);
        for (int i = 0; i < 3; i++) begin
            spi_byte(8'h00, rx);
            check($sformatf("abort_rdid_b%0d", i), rx, exp_id[i]);
        end
        cs_end();

        // Unknown command, then async reset in the middle of a byte
        rd_base = rd_cnt;
        cs_start();
        spi_byte(8'hAB, rx);
        for (int i = 0; i < 3; i++) begin
            spi_byte(8'h00, rx);
            check($sformatf("ignore_b%0d", i), rx, 8'h00);
        end
        check("ignore_no_memrd", rd_cnt - rd_base, 0);
        check("ignore_cmdbyte", bus.cmdByte, 8'hAB);
        check("ignore_busy", bus.busy, 1);
        spi_bits(8'hF0, 4, rx);
        bus.spiSclk = 1'b1;
        tick(3);
        #3;
        rst = 1'b1;
        #1;
        check("arst_miso",     bus.spiMiso,  0);
        check("arst_memaddr",  bus.memAddr,  0);
        check("arst_memrd",    bus.memRd,    0);
        check("arst_busy",     bus.busy,     0);
        check("arst_cmdvalid", bus.cmdValid, 0);
        check("arst_cmdbyte",  bus.cmdByte,  0);
        bus.spiCs   = 1'b1;
        bus.spiSclk = 1'b0;
        tick(4);
        rst = 1'b0;
        tick(4);

        // Fresh transaction after reset
        cs_start();
        spi_byte(CMD_RDID, rx);
        spi_byte(8'h00, rx);
        check("post_rst_rdid", rx, 8'hEF);
        cs_end();

        check("single_cycle_pulses", viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
